aha_en_rate_bridge: RTL and testbench

Carries a valid/ready data stream from logic running at full CLK rate into logic that advances only on a clock-enable pulse (By2CLKEN … By32CLKEN from the platform enable generator). The block is the consumer side of the clock-enable scheme. It buffers words written at full rate and presents them on an enable-qualified output port whose outputs change only on enable cycles. Slow-domain logic therefore sees values that are stable for the whole divided period. It sits in the platform controller between fast-side control logic and peripherals clocked by CLK gated with an enable.

---
 rtl/aha_en_rate_bridge_pkg.sv | 33 +++
 rtl/aha_en_period_check.sv | 59 +++++
 rtl/aha_en_rate_bridge.sv | 84 ++++++++
 tb/tb_aha_en_rate_bridge.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/aha_en_rate_bridge_pkg.sv
// Shared definitions for the full-rate to clock-enable bridge and its enable-period checker.
package aha_en_rate_bridge_pkg;

  // Ceiling log2, used to size pointers and counters.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Enable periods the platform enable generator can produce (By2CLKEN .. By32CLKEN).
  localparam int NUM_RATIOS = 5;
  localparam int LEGAL_RATIOS [NUM_RATIOS] = '{2, 4, 8, 16, 32};

  function automatic bit is_legal_ratio(input int ratio);
    bit legal;
    legal = 1'b0;
    for (int i = 0; i < NUM_RATIOS; i++) begin
      if (LEGAL_RATIOS[i] == ratio) legal = 1'b1;
    end
    return legal;
  endfunction

  // M_DATA reset value, replicated to DATA_W.
  localparam logic M_DATA_RST_BIT = 1'b0;

  typedef enum logic {
    CHK_IDLE,
    CHK_RUN
  } chk_state_t;

endpackage

// File: rtl/aha_en_period_check.sv
// Measures spacing between CLKEN pulses and raises a sticky EN_ERR when it differs from RATIO.
module aha_en_period_check
  import aha_en_rate_bridge_pkg::*;
#(
  parameter int RATIO = 2
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic CLKEN,
  output logic EN_ERR
);

  localparam int CW = clog2(RATIO) + 1;
  localparam logic [CW-1:0] RATIO_CNT = CW'(RATIO);

  chk_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic err_n;

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state  <= CHK_IDLE;
      cnt    <= '0;
      EN_ERR <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      EN_ERR <= err_n;
    end
  end

  // cnt holds the cycles elapsed since the last pulse; a missing pulse is flagged
  // on the edge where it was due, and the counter then parks at RATIO.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_n   = EN_ERR;
    case (state)
      CHK_IDLE: begin
        if (CLKEN) begin
          state_n = CHK_RUN;
          cnt_n   = CW'(1);
        end
      end
      CHK_RUN: begin
        if (CLKEN) begin
          if (cnt != RATIO_CNT) err_n = 1'b1;
          cnt_n = CW'(1);
        end else if (cnt == RATIO_CNT) begin
          err_n = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = CHK_IDLE;
    endcase
  end

endmodule

// File: rtl/aha_en_rate_bridge.sv
// Full-rate valid/ready FIFO feeding an output register that advances only on CLKEN.
// Optional enable-period checker built when AHA_EN_RATE_CHECK_EN is defined.
module aha_en_rate_bridge
  import aha_en_rate_bridge_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int RATIO  = 2
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              CLKEN,
  input  logic              S_VALID,
  output logic              S_READY,
  input  logic [DATA_W-1:0] S_DATA,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic [DATA_W-1:0] M_DATA,
  output logic              EN_ERR
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              wr_en, pop, fifo_empty;

  assign fifo_empty = (count == '0);
  assign S_READY    = (count != FULL_CNT);
  assign wr_en      = S_VALID && S_READY;
  // Uses the registered count, so a word written this cycle waits for the next CLKEN.
  assign pop        = CLKEN && (!M_VALID || M_READY) && !fifo_empty;

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= S_DATA;
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Output register only moves on enable cycles so the slow side sees stable values.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      M_VALID <= 1'b0;
      M_DATA  <= {DATA_W{M_DATA_RST_BIT}};
    end else if (CLKEN) begin
      if (pop) begin
        M_VALID <= 1'b1;
        M_DATA  <= mem[rd_ptr];
      end else if (M_VALID && M_READY) begin
        M_VALID <= 1'b0;
      end
    end
  end

`ifdef AHA_EN_RATE_CHECK_EN
  aha_en_period_check #(
    .RATIO(RATIO)
  ) u_period_check (
    .CLK   (CLK),
    .RESETn(RESETn),
    .CLKEN (CLKEN),
    .EN_ERR(EN_ERR)
  );
`else
  assign EN_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_aha_en_rate_bridge.sv
// Scoreboard bench for aha_en_rate_bridge: queue-level reference model plus a transfer monitor.
module tb_aha_en_rate_bridge;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int RATIO  = 4;
`ifdef AHA_EN_RATE_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RESETn, CLKEN, S_VALID, S_READY, M_VALID, M_READY, EN_ERR;
  logic [DATA_W-1:0] S_DATA, M_DATA;

  always #5 CLK = ~CLK;

  aha_en_rate_bridge #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .RATIO (RATIO)
  ) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .CLKEN  (CLKEN),
    .S_VALID(S_VALID),
    .S_READY(S_READY),
    .S_DATA (S_DATA),
    .M_VALID(M_VALID),
    .M_READY(M_READY),
    .M_DATA (M_DATA),
    .EN_ERR (EN_ERR)
  );

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] word_src [$];
  logic [DATA_W-1:0] sb_q [$];
  logic [DATA_W-1:0] mdl_fifo [$];
  bit                mdl_valid;
  logic [DATA_W-1:0] mdl_data;
  bit                mdl_err;
  int                cyc;
  int                last_pulse;
  int                word_cnt = 0;

  task automatic checkVal(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit rst_n, input bit en, input bit sv, input bit mr);
    RESETn  = rst_n;
    CLKEN   = en;
    M_READY = mr;
    S_VALID = sv && (word_src.size() > 0);
    S_DATA  = (word_src.size() > 0) ? word_src[0] : '0;
  endtask

  // Reference behaviour: words queue up to DEPTH, one leaves per enable when the slot is free.
  task automatic modelStep();
    bit accepted, xfer;
    if (!RESETn) begin
      mdl_fifo.delete();
      sb_q.delete();
      mdl_valid  = 1'b0;
      mdl_data   = '0;
      mdl_err    = 1'b0;
      cyc        = 0;
      last_pulse = -1;
      return;
    end
    accepted = S_VALID && (mdl_fifo.size() < DEPTH);
    if (CLKEN) begin
      xfer = mdl_valid && M_READY;
      if ((!mdl_valid || xfer) && mdl_fifo.size() > 0) begin
        mdl_data  = mdl_fifo.pop_front();
        mdl_valid = 1'b1;
      end else if (xfer) begin
        mdl_valid = 1'b0;
      end
    end
    if (accepted) begin
      mdl_fifo.push_back(S_DATA);
      sb_q.push_back(S_DATA);
      void'(word_src.pop_front());
    end
    cyc++;
    if (CLKEN) begin
      if (last_pulse >= 0 && (cyc - last_pulse) != RATIO) mdl_err = 1'b1;
      last_pulse = cyc;
    end else if (last_pulse >= 0 && (cyc - last_pulse) >= RATIO) begin
      mdl_err = 1'b1;
    end
  endtask

  task automatic checkOutput();
    checkVal("s_ready", {31'b0, S_READY}, {31'b0, (mdl_fifo.size() < DEPTH)});
    checkVal("m_valid", {31'b0, M_VALID}, {31'b0, mdl_valid});
    checkVal("m_data",  M_DATA, mdl_data);
    checkVal("en_err",  {31'b0, EN_ERR}, {31'b0, (CHK_EN && mdl_err)});
  endtask

  task automatic step(input bit rst_n, input bit en, input bit sv, input bit mr);
    applyStimulus(rst_n, en, sv, mr);
    @(posedge CLK);
    #1;
    modelStep();
    checkOutput();
  endtask

  task automatic runCycles(input int n, input int period, input bit sv, input bit mr);
    for (int i = 0; i < n; i++) step(1'b1, (i % period) == (period - 1), sv, mr);
  endtask

  task automatic pushWords(input int n);
    for (int i = 0; i < n; i++) begin
      word_cnt++;
      word_src.push_back(32'hC0DE_0000 + DATA_W'(word_cnt));
    end
  endtask

  // Monitor: a slow-side transfer is committed at the next edge when these are all high.
  always @(negedge CLK) begin
    if (RESETn === 1'b1 && CLKEN === 1'b1 && M_VALID === 1'b1 && M_READY === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL sb_unexpected at %0t: actual=%h required=none", $time, M_DATA);
      end else begin
        checkVal("sb_order", M_DATA, sb_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    word_src.delete();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset, then idle with CLKEN every 4 cycles.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    runCycles(16, 4, 1'b0, 1'b1);

    // Back-to-back burst, CLKEN every 2 cycles, slow side always ready.
    for (int i = 1; i <= 4; i++) word_src.push_back(32'hA5A5_0000 + DATA_W'(i));
    runCycles(20, 2, 1'b1, 1'b1);

    // Back-pressure: 6 offered, 5 held with M_READY low, then drain.
    pushWords(6);
    runCycles(40, 8, 1'b1, 1'b0);
    runCycles(64, 8, 1'b1, 1'b1);

    // Mid-stream reset with 3 words queued behind the output register.
    pushWords(4);
    runCycles(12, 2, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    pushWords(2);
    runCycles(16, 2, 1'b1, 1'b1);

    // Randomized segments with legal and mixed enable periods.
    for (int seg = 0; seg < 10; seg++) begin
      int period;
      period = 2 << $urandom_range(0, 2);
      for (int i = 0; i < 30; i++) begin
        if (word_src.size() == 0) word_src.push_back($urandom);
        step(1'b1, (i % period) == (period - 1), ($urandom % 4) != 0, ($urandom % 3) != 0);
      end
    end
    runCycles(40, 2, 1'b0, 1'b1);

    // Enable-period checker: pulses at 10, 14, 18, 21 after reset.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 30; i++) step(1'b1, (i == 10) || (i == 14) || (i == 18) || (i == 21), 1'b0, 1'b1);

    // Regular period after a fresh reset keeps EN_ERR low.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    runCycles(24, RATIO, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
